// File: rtl/instruction_decode_stage_if.sv
// Bus between the IF/ID register, writeback, EX hazard info and the ID/EX
// register produced by instruction_decode_stage.
interface instruction_decode_stage_if #(
  parameter int DATA_W = 32
);
  // Flow control: this stage has no valid/ready pair. busywait=1 freezes the
  // ID/EX register. load_use_stall=1 (combinational) tells fetch and IF/ID to
  // hold, so the same IN_instruction is offered again next cycle while a
  // bubble (OUT_ctrl=0) enters EX. flush=1 kills the instruction being
  // decoded, turning it into a bubble.
  logic              busywait;
  logic              flush;
  logic [31:0]       IN_instruction;
  logic [31:0]       IN_pc;
  logic [31:0]       IN_pc_plus_4;
  logic              wb_write_en;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_mem_read;
  logic [4:0]        ex_rd;
  logic              load_use_stall;
  logic [31:0]       OUT_pc;
  logic [31:0]       OUT_pc_plus_4;
  logic [DATA_W-1:0] OUT_rs1_data;
  logic [DATA_W-1:0] OUT_rs2_data;
  logic [31:0]       OUT_imm;
  logic [4:0]        OUT_rs1;
  logic [4:0]        OUT_rs2;
  logic [4:0]        OUT_rd;
  logic [2:0]        OUT_funct3;
  logic [14:0]       OUT_ctrl;

  modport master (
    output busywait, flush, IN_instruction, IN_pc, IN_pc_plus_4,
           wb_write_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  load_use_stall, OUT_pc, OUT_pc_plus_4, OUT_rs1_data, OUT_rs2_data,
           OUT_imm, OUT_rs1, OUT_rs2, OUT_rd, OUT_funct3, OUT_ctrl
  );

  modport slave (
    input  busywait, flush, IN_instruction, IN_pc, IN_pc_plus_4,
           wb_write_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    output load_use_stall, OUT_pc, OUT_pc_plus_4, OUT_rs1_data, OUT_rs2_data,
           OUT_imm, OUT_rs1, OUT_rs2, OUT_rd, OUT_funct3, OUT_ctrl
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32IM decode stage: register file with write-through bypass, immediate
// and control generation, load-use hazard detection, and the ID/EX register.
module instruction_decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_decode_stage_if.slave   bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_PASS_B = 5'd18;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Base-ISA ALU selection shared by OP and OP-IMM; only OP may pick SUB.
  function automatic logic [4:0] alu_from_funct(input logic [2:0] f3,
                                                input logic       alt,
                                                input logic       allow_sub);
    case (f3)
      3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [31:0]       r_pc;
  logic [31:0]       r_pc_plus_4;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [31:0]       r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic [14:0]       r_ctrl;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_instr  = bus.IN_instruction;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                    w_instr[20], w_instr[30:21], 1'b0};

  logic [31:0] w_imm;
  logic        w_reg_write;
  logic [1:0]  w_wb_sel;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_jalr;
  logic        w_op_a_pc;
  logic        w_op_b_imm;
  logic [4:0]  w_alu_op;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic [14:0] w_ctrl;

  // Opcode decode; unknown opcodes fall through with every control bit clear.
  always_comb begin
    w_imm       = '0;
    w_reg_write = 1'b0;
    w_wb_sel    = WB_ALU;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_jalr      = 1'b0;
    w_op_a_pc   = 1'b0;
    w_op_b_imm  = 1'b0;
    w_alu_op    = ALU_ADD;
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_imm = w_imm_u; w_reg_write = 1'b1; w_op_b_imm = 1'b1;
        w_alu_op = ALU_PASS_B; w_rs1_used = 1'b0;
      end
      OPC_AUIPC: begin
        w_imm = w_imm_u; w_reg_write = 1'b1; w_op_a_pc = 1'b1;
        w_op_b_imm = 1'b1; w_rs1_used = 1'b0;
      end
      OPC_JAL: begin
        w_imm = w_imm_j; w_reg_write = 1'b1; w_wb_sel = WB_PC4;
        w_jump = 1'b1; w_rs1_used = 1'b0;
      end
      OPC_JALR: begin
        w_imm = w_imm_i; w_reg_write = 1'b1; w_wb_sel = WB_PC4;
        w_jump = 1'b1; w_jalr = 1'b1; w_op_b_imm = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_branch = 1'b1; w_alu_op = ALU_SUB;
        w_rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_reg_write = 1'b1; w_wb_sel = WB_MEM;
        w_mem_read = 1'b1; w_op_b_imm = 1'b1;
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_mem_write = 1'b1; w_op_b_imm = 1'b1;
        w_rs2_used = 1'b1;
      end
      OPC_OP_IMM: begin
        w_imm = w_imm_i; w_reg_write = 1'b1; w_op_b_imm = 1'b1;
        w_alu_op = alu_from_funct(w_funct3, w_funct7[5], 1'b0);
      end
      OPC_OP: begin
        w_reg_write = 1'b1; w_rs2_used = 1'b1;
        if (w_funct7 == 7'b0000001) w_alu_op = ALU_MUL + {2'b00, w_funct3};
        else w_alu_op = alu_from_funct(w_funct3, w_funct7[5], 1'b1);
      end
      default: ;
    endcase
    w_ctrl = {w_reg_write, w_wb_sel, w_mem_read, w_mem_write, w_branch,
              w_jump, w_jalr, w_op_a_pc, w_op_b_imm, w_alu_op};
  end

  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  // Register reads: x0 is zero, a same-cycle writeback is forwarded.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (bus.wb_write_en && bus.wb_rd == w_rs1) w_rs1_data = bus.wb_data;
    if (bus.wb_write_en && bus.wb_rd == w_rs2) w_rs2_data = bus.wb_data;
    if (w_rs1 == 5'd0) w_rs1_data = '0;
    if (w_rs2 == 5'd0) w_rs2_data = '0;
  end

  logic w_hazard;
  assign w_hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) && !bus.flush &&
                    ((w_rs1_used && bus.ex_rd == w_rs1) ||
                     (w_rs2_used && bus.ex_rd == w_rs2));
  assign bus.load_use_stall = w_hazard;

  // Register file write; writeback is never frozen by busywait.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_write_en && bus.wb_rd != 5'd0) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ID/EX register: reset, then busywait hold, then bubble on flush/hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_pc_plus_4 <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_ctrl      <= '0;
    end else if (!bus.busywait) begin
      r_pc        <= bus.IN_pc;
      r_pc_plus_4 <= bus.IN_pc_plus_4;
      r_rs1_data  <= w_rs1_data;
      r_rs2_data  <= w_rs2_data;
      r_imm       <= w_imm;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_funct3    <= w_funct3;
      r_ctrl      <= (bus.flush || w_hazard) ? 15'd0 : w_ctrl;
    end
  end

  assign bus.OUT_pc        = r_pc;
  assign bus.OUT_pc_plus_4 = r_pc_plus_4;
  assign bus.OUT_rs1_data  = r_rs1_data;
  assign bus.OUT_rs2_data  = r_rs2_data;
  assign bus.OUT_imm       = r_imm;
  assign bus.OUT_rs1       = r_rs1;
  assign bus.OUT_rs2       = r_rs2;
  assign bus.OUT_rd        = r_rd;
  assign bus.OUT_funct3    = r_funct3;
  assign bus.OUT_ctrl      = r_ctrl;

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
Second CPU pipeline stage. It consumes the IF/ID register outputs (instruction, PC, PC+4) and decodes RV32IM. It holds the 32x32 register file, generates immediates and control, and detects load-use hazards. Its outputs are registered as the ID/EX pipeline register that feeds the execute stage.

Parameters:
DATA_W, 32, datapath and register width
NUM_REGS, 32, architectural register count (x0 hardwired to zero)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
busywait  input  1  global memory stall; freezes this stage
flush  input  1  jump/branch taken in EX; kill the instruction being decoded
IN_instruction  input  32  from IF/ID register
IN_pc  input  32  PC of IN_instruction
IN_pc_plus_4  input  32  PC+4 of IN_instruction
wb_write_en  input  1  writeback register-write enable
wb_rd  input  5  writeback destination
wb_data  input  32  writeback value
ex_mem_read  input  1  the instruction currently in EX is a load
ex_rd  input  5  destination register of the instruction in EX
load_use_stall  output  1  combinational; upstream (fetch, IF/ID) must hold
OUT_pc, OUT_pc_plus_4  output  32 each  registered copies
OUT_rs1_data, OUT_rs2_data  output  32 each  register operands
OUT_imm  output  32  sign-extended immediate
OUT_rs1, OUT_rs2, OUT_rd  output  5 each  register indices
OUT_funct3  output  3  for branch/memory size in later stages
OUT_ctrl  output  15  [14] reg_write, [13:12] wb_sel (00 alu, 01 mem, 10 pc+4), [11] mem_read, [10] mem_write, [9] branch, [8] jump, [7] jalr, [6] op_a_pc, [5] op_b_imm, [4:0] alu_op

Behaviour:
- Register file, synchronous write:
  - On clk, if wb_write_en and wb_rd!=0, then reg[wb_rd] <= wb_data.
  - Reads are combinational, with write-through bypass: a read of wb_rd in the same cycle as its write returns wb_data.
  - x0 always reads 0.
  - Writes are not gated by busywait.
  - Reset clears all registers to 0.
- Immediate generation (all forms sign-extended from bit 31):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and unknown: 0.
- alu_op encoding:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
  - PASS_B 18.
- Control by opcode:
  - LUI: alu_op PASS_B, op_b_imm=1.
  - AUIPC: op_a_pc=1, ADD.
  - JAL: jump=1, wb_sel 10.
  - JALR: jump=1, jalr=1, wb_sel 10.
  - Branch: branch=1, SUB.
  - Load: mem_read=1, wb_sel 01, ADD imm.
  - Store: mem_write=1, ADD imm, no reg_write.
  - OP-IMM and OP: funct3/funct7 decode; funct7=0000001 selects the M extension.
  - All writers other than stores and branches set reg_write.
  - Illegal opcode produces a bubble (OUT_ctrl=0).
- load_use_stall is 1 when all of the following hold:
  - ex_mem_read=1 and ex_rd!=0;
  - ex_rd matches rs1 (only if rs1 is used: not LUI/AUIPC/JAL) or rs2 (only for R/S/B formats);
  - flush=0.
- Register update priority on each clk edge:
  1. reset: all outputs become 0. OUT_ctrl=0 is the bubble.
  2. busywait=1: hold all outputs; flush and load_use are ignored.
  3. flush=1: OUT_ctrl <= 0 (bubble). Other fields are don't-care but are loaded normally.
  4. load_use_stall=1: OUT_ctrl <= 0 (bubble). The same IN_instruction is re-decoded next cycle because upstream holds.
  5. Otherwise: load the decoded values.
- Latency: 1 cycle from IN_instruction to OUT_*.
- Reset mid-stall: reset wins and the stall state is not retained.

Test Plan:
- Reset: assert reset 2 cycles with IN_instruction=0x002081B3 -> all OUT_* = 0, load_use_stall=0.
- ADDI x1,x0,-5 (0xFFB00093) -> next cycle OUT_rd=1, OUT_imm=0xFFFFFFFB, reg_write=1, op_b_imm=1, alu_op=0.
- Bypass and x0:
  - wb x5=0x1234 in the same cycle as decoding ADD x3,x5,x0 (0x000281B3) -> OUT_rs1_data=0x1234.
  - wb x0=0xFFFF -> x0 still reads 0.
- MUL x3,x1,x2 (0x022081B3) with x1=6, x2=7 -> alu_op=10, OUT_rs1_data=6, OUT_rs2_data=7, OUT_rd=3.
- Load-use:
  - ex_mem_read=1, ex_rd=1, decoding ADD x3,x1,x2 -> load_use_stall=1 and OUT_ctrl=0 next cycle.
  - ex_mem_read dropped -> full decode the following cycle.
  - Same hazard with flush=1 -> load_use_stall=0.
- Busywait/flush:
  - busywait=1 for 3 cycles while flush=1 -> outputs frozen.
  - busywait falls with flush still 1 -> OUT_ctrl=0 next cycle.
